// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: source select, load size and
// fixed constants used by wb_stage and its load alignment helper.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_B    = 2'd0,
        LD_H    = 2'd1,
        LD_W    = 2'd2,
        LD_RSVD = 2'd3
    } ld_size_e;

    localparam logic [4:0]  REG_ZERO    = 5'd0;
    localparam logic [31:0] LINK_OFFSET = 32'd8;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational little-endian load extraction with sign/zero extension and
// misalignment detection; the reserved size encoding behaves as a word load.
module wb_stage_load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] read_data_i,
    input  logic [1:0]      off_i,
    input  ld_size_e        ld_size_i,
    input  logic            ld_unsigned_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = read_data_i[7:0];
        case (off_i)
            2'd0:    byte_v = read_data_i[7:0];
            2'd1:    byte_v = read_data_i[15:8];
            2'd2:    byte_v = read_data_i[23:16];
            default: byte_v = read_data_i[31:24];
        endcase
        half_v = off_i[1] ? read_data_i[31:16] : read_data_i[15:0];
    end

    always_comb begin
        data_o       = read_data_i;
        misaligned_o = 1'b0;
        case (ld_size_i)
            LD_B: begin
                data_o = {{(XLEN-8){~ld_unsigned_i & byte_v[7]}}, byte_v};
            end
            LD_H: begin
                data_o       = {{(XLEN-16){~ld_unsigned_i & half_v[15]}}, half_v};
                misaligned_o = off_i[0];
            end
            default: begin
                data_o       = read_data_i;
                misaligned_o = (off_i != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, source select, register-file write port,
// retired counter and sticky fault. Optional trace outputs under WB_TRACE_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEMtoWB_valid,
    input  logic [31:0]      MEMtoWB_PC,
    input  logic [XLEN-1:0]  MEMtoWB_ALUResult,
    input  logic [XLEN-1:0]  MEMtoWB_ReadData,
    input  logic [4:0]       MEMtoWB_Rd,
    input  logic             MEMtoWB_RegWrite,
    input  logic [1:0]       MEMtoWB_WBSel,
    input  logic [1:0]       MEMtoWB_LdSize,
    input  logic             MEMtoWB_LdUnsigned,
    input  logic             stall,
    input  logic             flush,
    output logic [4:0]       writeReg,
    output logic [XLEN-1:0]  writeData,
    output logic             RegWrite,
    output logic [CNT_W-1:0] retired,
    output logic             fault
`ifdef WB_TRACE_EN
    ,
    output logic             trace_valid,
    output logic [31:0]      trace_PC,
    output logic [4:0]       trace_Rd,
    output logic [XLEN-1:0]  trace_Data
`endif
);

    logic            valid_q;
    logic [31:0]     pc_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] rdata_q;
    logic [4:0]      rd_q;
    logic            rw_q;
    wb_sel_e         wbsel_q;
    ld_size_e        ldsize_q;
    logic            ldu_q;

    logic [CNT_W-1:0] retired_q, retired_d;
    logic             fault_q, fault_d;

    logic [XLEN-1:0] load_data;
    logic            ld_misaligned;
    logic            misaligned;
    logic            advance;
    logic [31:0]     link_pc;
    logic [XLEN-1:0] wdata;

    // MEM/WB register: flush inserts a bubble, stall holds the entry
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            alu_q    <= '0;
            rdata_q  <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            wbsel_q  <= WB_ALU;
            ldsize_q <= LD_B;
            ldu_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
        end else if (!stall) begin
            valid_q  <= MEMtoWB_valid;
            pc_q     <= MEMtoWB_PC;
            alu_q    <= MEMtoWB_ALUResult;
            rdata_q  <= MEMtoWB_ReadData;
            rd_q     <= MEMtoWB_Rd;
            rw_q     <= MEMtoWB_RegWrite;
            wbsel_q  <= wb_sel_e'(MEMtoWB_WBSel);
            ldsize_q <= ld_size_e'(MEMtoWB_LdSize);
            ldu_q    <= MEMtoWB_LdUnsigned;
        end
    end

    wb_stage_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .read_data_i   (rdata_q),
        .off_i         (alu_q[1:0]),
        .ld_size_i     (ldsize_q),
        .ld_unsigned_i (ldu_q),
        .data_o        (load_data),
        .misaligned_o  (ld_misaligned)
    );

    // An entry writes and retires only in the cycle it leaves the stage
    always_comb begin
        misaligned = (wbsel_q == WB_MEM) & ld_misaligned;
        advance    = valid_q & ~stall & ~rst;
        link_pc    = pc_q + LINK_OFFSET;
        wdata      = '0;
        case (wbsel_q)
            WB_ALU:  wdata = alu_q;
            WB_MEM:  wdata = load_data;
            WB_LINK: wdata = XLEN'(link_pc);
            default: wdata = '0;
        endcase
        retired_d = retired_q + CNT_W'(advance);
        fault_d   = fault_q | (valid_q & (misaligned | (wbsel_q == WB_RSVD)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    assign writeReg  = rd_q;
    assign writeData = wdata;
    assign RegWrite  = advance & rw_q & (rd_q != REG_ZERO) & ~misaligned;
    assign retired   = retired_q;
    assign fault     = fault_q;

`ifdef WB_TRACE_EN
    logic            trace_valid_q;
    logic [31:0]     trace_pc_q;
    logic [4:0]      trace_rd_q;
    logic [XLEN-1:0] trace_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_rd_q    <= '0;
            trace_data_q  <= '0;
        end else if (advance) begin
            trace_valid_q <= 1'b1;
            trace_pc_q    <= pc_q;
            trace_rd_q    <= rd_q;
            trace_data_q  <= wdata;
        end else begin
            trace_valid_q <= 1'b0;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_PC    = trace_pc_q;
    assign trace_Rd    = trace_rd_q;
    assign trace_Data  = trace_data_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage with hand-computed expectations.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEMtoWB_valid;
    logic [31:0] MEMtoWB_PC;
    logic [31:0] MEMtoWB_ALUResult;
    logic [31:0] MEMtoWB_ReadData;
    logic [4:0]  MEMtoWB_Rd;
    logic        MEMtoWB_RegWrite;
    logic [1:0]  MEMtoWB_WBSel;
    logic [1:0]  MEMtoWB_LdSize;
    logic        MEMtoWB_LdUnsigned;
    logic        stall;
    logic        flush;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        RegWrite;
    logic [31:0] retired;
    logic        fault;
`ifdef WB_TRACE_EN
    logic        trace_valid;
    logic [31:0] trace_PC;
    logic [4:0]  trace_Rd;
    logic [31:0] trace_Data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk                (clk),
        .rst                (rst),
        .MEMtoWB_valid      (MEMtoWB_valid),
        .MEMtoWB_PC         (MEMtoWB_PC),
        .MEMtoWB_ALUResult  (MEMtoWB_ALUResult),
        .MEMtoWB_ReadData   (MEMtoWB_ReadData),
        .MEMtoWB_Rd         (MEMtoWB_Rd),
        .MEMtoWB_RegWrite   (MEMtoWB_RegWrite),
        .MEMtoWB_WBSel      (MEMtoWB_WBSel),
        .MEMtoWB_LdSize     (MEMtoWB_LdSize),
        .MEMtoWB_LdUnsigned (MEMtoWB_LdUnsigned),
        .stall              (stall),
        .flush              (flush),
        .writeReg           (writeReg),
        .writeData          (writeData),
        .RegWrite           (RegWrite),
        .retired            (retired),
        .fault              (fault)
`ifdef WB_TRACE_EN
        ,
        .trace_valid        (trace_valid),
        .trace_PC           (trace_PC),
        .trace_Rd           (trace_Rd),
        .trace_Data         (trace_Data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                        input logic [1:0] size, input logic uns);
        MEMtoWB_valid      = 1'b1;
        MEMtoWB_PC         = pc;
        MEMtoWB_ALUResult  = alu;
        MEMtoWB_ReadData   = rdata;
        MEMtoWB_Rd         = rd;
        MEMtoWB_RegWrite   = rw;
        MEMtoWB_WBSel      = sel;
        MEMtoWB_LdSize     = size;
        MEMtoWB_LdUnsigned = uns;
        step();
    endtask

    task automatic idle();
        MEMtoWB_valid    = 1'b0;
        MEMtoWB_RegWrite = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        MEMtoWB_valid = 1'b0; MEMtoWB_PC = '0; MEMtoWB_ALUResult = '0;
        MEMtoWB_ReadData = '0; MEMtoWB_Rd = '0; MEMtoWB_RegWrite = 1'b0;
        MEMtoWB_WBSel = 2'd0; MEMtoWB_LdSize = 2'd0; MEMtoWB_LdUnsigned = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_writeReg",  32'(writeReg), 0);
        chk("rst_writeData", writeData, 0);
        chk("rst_RegWrite",  32'(RegWrite), 0);
        chk("rst_retired",   retired, 0);
        chk("rst_fault",     32'(fault), 0);

        send(32'h0, 32'h12345678, 32'h0, 5'd8, 1'b1, 2'd0, 2'd0, 1'b0);
        chk("alu_RegWrite",  32'(RegWrite), 1);
        chk("alu_writeReg",  32'(writeReg), 8);
        chk("alu_writeData", writeData, 32'h12345678);
        chk("alu_retired_pre", retired, 0);
        idle();
        chk("alu_retired", retired, 1);
        chk("idle_RegWrite", 32'(RegWrite), 0);
`ifdef WB_TRACE_EN
        chk("trace_valid", 32'(trace_valid), 1);
        chk("trace_Data",  trace_Data, 32'h12345678);
        chk("trace_Rd",    32'(trace_Rd), 8);
`endif

        send(32'h0, 32'h00001001, 32'h80FF7F01, 5'd5, 1'b1, 2'd1, 2'd0, 1'b0);
        chk("lb_off1",      writeData, 32'h0000007F);
        chk("lb_off1_we",   32'(RegWrite), 1);
        send(32'h0, 32'h00001003, 32'h80FF7F01, 5'd5, 1'b1, 2'd1, 2'd0, 1'b0);
        chk("lb_off3",      writeData, 32'hFFFFFF80);
        send(32'h0, 32'h00001003, 32'h80FF7F01, 5'd5, 1'b1, 2'd1, 2'd0, 1'b1);
        chk("lbu_off3",     writeData, 32'h00000080);
        send(32'h0, 32'h00001002, 32'h80FF7F01, 5'd5, 1'b1, 2'd1, 2'd1, 1'b0);
        chk("lh_off2",      writeData, 32'hFFFF80FF);
        send(32'h0, 32'h00001000, 32'h80FF7F01, 5'd5, 1'b1, 2'd1, 2'd2, 1'b0);
        chk("lw_off0",      writeData, 32'h80FF7F01);
        chk("lw_off0_we",   32'(RegWrite), 1);

        send(32'h00400010, 32'h0, 32'h0, 5'd31, 1'b1, 2'd2, 2'd0, 1'b0);
        chk("link_data",    writeData, 32'h00400018);
        chk("link_reg",     32'(writeReg), 31);
        send(32'hFFFFFFF8, 32'h0, 32'h0, 5'd31, 1'b1, 2'd2, 2'd0, 1'b0);
        chk("link_wrap",    writeData, 32'h00000000);

        send(32'h0, 32'hDEADBEEF, 32'h0, 5'd0, 1'b1, 2'd0, 2'd0, 1'b0);
        chk("x0_RegWrite",  32'(RegWrite), 0);
        idle();
        chk("x0_retired",   retired, 9);

        send(32'h0, 32'h0000A5A5, 32'h0, 5'd9, 1'b1, 2'd0, 2'd0, 1'b0);
        MEMtoWB_valid = 1'b0; MEMtoWB_RegWrite = 1'b0;
        stall = 1'b1;
        #1;
        chk("stall1_we", 32'(RegWrite), 0);
        step();
        chk("stall2_we", 32'(RegWrite), 0);
        step();
        chk("stall3_we", 32'(RegWrite), 0);
        chk("stall_retired", retired, 9);
        stall = 1'b0;
        #1;
        chk("unstall_we",   32'(RegWrite), 1);
        chk("unstall_reg",  32'(writeReg), 9);
        chk("unstall_data", writeData, 32'h0000A5A5);
        step();
        chk("unstall_once", 32'(RegWrite), 0);
        chk("stall_retired_post", retired, 10);

        stall = 1'b1; flush = 1'b1;
        send(32'h0, 32'h11111111, 32'h0, 5'd10, 1'b1, 2'd0, 2'd0, 1'b0);
        stall = 1'b0; flush = 1'b0;
        MEMtoWB_valid = 1'b0; MEMtoWB_RegWrite = 1'b0;
        #1;
        chk("flush_we", 32'(RegWrite), 0);
        step();
        chk("flush_retired", retired, 10);

        send(32'h0, 32'h00002001, 32'h80FF7F01, 5'd6, 1'b1, 2'd1, 2'd1, 1'b0);
        chk("mis_half_we",    32'(RegWrite), 0);
        chk("mis_half_fault_pre", 32'(fault), 0);
        idle();
        chk("mis_half_fault", 32'(fault), 1);
        chk("mis_half_retired", retired, 11);
        send(32'h0, 32'h00002002, 32'h80FF7F01, 5'd6, 1'b1, 2'd1, 2'd2, 1'b0);
        chk("mis_word_we",    32'(RegWrite), 0);
        idle();
        chk("mis_word_retired", retired, 12);

        send(32'h0, 32'h55555555, 32'h0, 5'd7, 1'b1, 2'd3, 2'd0, 1'b0);
        chk("rsvd_data",      writeData, 0);
        idle();
        chk("rsvd_retired",   retired, 13);
        chk("fault_sticky",   32'(fault), 1);

        send(32'h0, 32'h0000BEEF, 32'h0, 5'd11, 1'b1, 2'd0, 2'd0, 1'b0);
        MEMtoWB_valid = 1'b0; MEMtoWB_RegWrite = 1'b0;
        stall = 1'b1;
        step();
        rst = 1'b1;
        #1;
        chk("rst_stall_we", 32'(RegWrite), 0);
        step();
        rst = 1'b0; stall = 1'b0;
        #1;
        chk("rst2_writeReg",  32'(writeReg), 0);
        chk("rst2_writeData", writeData, 0);
        chk("rst2_RegWrite",  32'(RegWrite), 0);
        chk("rst2_retired",   retired, 0);
        chk("rst2_fault",     32'(fault), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
